jtag_scan_driver: RTL and testbench

Command-driven JTAG master that sits directly upstream of the boundary-scan TAP block and produces its TMS/TDI stimulus while collecting its TDO. A host-side command (reset, IR scan, DR scan, run-test) is accepted over a valid/ready handshake. The block walks the TAP through the required state path, shifts the payload LSB-first and returns captured TDO bits over a response handshake. It is the only agent driving TMS/TDI in test mode.

---
 rtl/jtag_scan_driver_pkg.sv | 56 +++++
 rtl/jtag_scan_driver_tap_state_mirror.sv | 17 +
 rtl/jtag_scan_driver.sv | 159 +++++++++++++++
 tb/tb_jtag_scan_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_scan_driver_pkg.sv
// Shared types for the JTAG scan driver: op codes, FSM and TAP state encodings,
// preamble TMS patterns and the 16-state TAP next-state function.
package jtag_scan_driver_pkg;

   typedef enum logic [1:0] {
      OP_RESET   = 2'b00,
      OP_IR_SCAN = 2'b01,
      OP_DR_SCAN = 2'b10,
      OP_RUNTEST = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_PRE, ST_SHIFT, ST_POST, ST_RUN, ST_RSP
   } fsm_t;

   // Customary 1149.1 four-bit TAP state encoding
   typedef enum logic [3:0] {
      TAP_EXIT2_DR = 4'h0, TAP_EXIT1_DR = 4'h1, TAP_SHIFT_DR = 4'h2, TAP_PAUSE_DR = 4'h3,
      TAP_SEL_IR   = 4'h4, TAP_UPD_DR   = 4'h5, TAP_CAP_DR   = 4'h6, TAP_SEL_DR   = 4'h7,
      TAP_EXIT2_IR = 4'h8, TAP_EXIT1_IR = 4'h9, TAP_SHIFT_IR = 4'hA, TAP_PAUSE_IR = 4'hB,
      TAP_RTI      = 4'hC, TAP_UPD_IR   = 4'hD, TAP_CAP_IR   = 4'hE, TAP_TLR      = 4'hF
   } tap_state_t;

   // Preamble TMS patterns are emitted LSB first
   localparam logic [7:0] IR_PRE_TMS  = 8'b0000_0011;
   localparam int         IR_PRE_LEN  = 4;
   localparam logic [7:0] DR_PRE_TMS  = 8'b0000_0001;
   localparam int         DR_PRE_LEN  = 3;
   localparam logic [7:0] RST_PRE_TMS = 8'b0001_1111;
   localparam int         RST_PRE_LEN = 6;

   localparam logic [1:0] BYPASS_IR = 2'b11;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      case (s)
         TAP_TLR:      tap_next = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   tap_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   tap_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: tap_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: tap_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: tap_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: tap_next = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   tap_next = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   tap_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: tap_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: tap_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: tap_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: tap_next = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
         TAP_UPD_IR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
         default:      tap_next = TAP_TLR;
      endcase
   endfunction

endpackage

// File: rtl/jtag_scan_driver_tap_state_mirror.sv
// Tracks the downstream TAP state from the TMS stream driven into it.
// One TCK per transition; held in Test-Logic-Reset while Reset is high.
module tap_state_mirror
   import jtag_scan_driver_pkg::*;
(
   input  logic       TCK,
   input  logic       Reset,
   input  logic       TMS,
   output tap_state_t tap_state
);

   always_ff @(posedge TCK) begin
      if (Reset) tap_state <= TAP_TLR;
      else       tap_state <= tap_next(tap_state, TMS);
   end

endmodule

// File: rtl/jtag_scan_driver.sv
// Command-driven JTAG master: walks the TAP, shifts payload LSB-first, returns TDO.
// Optional RUNTEST idling is built only when JTAG_SCAN_DRIVER_RUNTEST_EN is defined.
module jtag_scan_driver
   import jtag_scan_driver_pkg::*;
#(
   parameter  int N         = 16,
   localparam int CHAIN_LEN = 3*N + 3,
   localparam int LEN_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 TCK,
   input  logic                 Reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [LEN_W-1:0]     cmd_len,
   input  logic [CHAIN_LEN-1:0] cmd_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_data,
   output logic                 TMS,
   output logic                 TDI,
   input  logic                 TDO,
   output logic [3:0]           tap_state
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(CHAIN_LEN);

   fsm_t                 state, state_nxt;
   op_t                  op_q;
   logic [LEN_W-1:0]     len_q, cnt, len_clamp, pre_last;
   logic [CHAIN_LEN-1:0] data_q, rsp_q;
   logic [7:0]           pre_tms;
   logic                 cnt_clr, accept, shift_en, tdo_bit;
   tap_state_t           tap_q;

   assign len_clamp = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
   // Undriven or unknown TDO is captured as 0
   assign tdo_bit   = (TDO === 1'b1);
   assign rsp_data  = rsp_q;
   assign tap_state = tap_q;

   always_comb begin
      pre_tms  = RST_PRE_TMS;
      pre_last = LEN_W'(RST_PRE_LEN - 1);
      case (op_q)
         OP_IR_SCAN: begin
            pre_tms  = IR_PRE_TMS;
            pre_last = LEN_W'(IR_PRE_LEN - 1);
         end
         OP_DR_SCAN: begin
            pre_tms  = DR_PRE_TMS;
            pre_last = LEN_W'(DR_PRE_LEN - 1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      TMS       = 1'b0;
      TDI       = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      cnt_clr   = 1'b0;
      accept    = 1'b0;
      shift_en  = 1'b0;
      case (state)
         ST_INIT: begin
            TMS = RST_PRE_TMS[cnt[2:0]];
            if (cnt == LEN_W'(RST_PRE_LEN - 1)) begin
               state_nxt = ST_IDLE;
               cnt_clr   = 1'b1;
            end
         end
         ST_IDLE: begin
            cmd_ready = 1'b1;
            cnt_clr   = 1'b1;
            if (cmd_valid) begin
               accept = 1'b1;
               case (op_t'(cmd_op))
                  OP_RESET:   state_nxt = ST_PRE;
`ifdef JTAG_SCAN_DRIVER_RUNTEST_EN
                  OP_RUNTEST: state_nxt = (cmd_len == '0) ? ST_RSP : ST_RUN;
`else
                  OP_RUNTEST: state_nxt = ST_RSP;
`endif
                  default:    state_nxt = (len_clamp == '0) ? ST_RSP : ST_PRE;
               endcase
            end
         end
         ST_PRE: begin
            TMS = pre_tms[cnt[2:0]];
            if (cnt == pre_last) begin
               state_nxt = (op_q == OP_RESET) ? ST_RSP : ST_SHIFT;
               cnt_clr   = 1'b1;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            TDI      = data_q[cnt];
            TMS      = (cnt == len_q - 1'b1);
            if (TMS) begin
               state_nxt = ST_POST;
               cnt_clr   = 1'b1;
            end
         end
         ST_POST: begin
            TMS = (cnt == '0);
            if (cnt == LEN_W'(1)) begin
               state_nxt = ST_RSP;
               cnt_clr   = 1'b1;
            end
         end
`ifdef JTAG_SCAN_DRIVER_RUNTEST_EN
         ST_RUN: begin
            if (cnt == len_q - 1'b1) begin
               state_nxt = ST_RSP;
               cnt_clr   = 1'b1;
            end
         end
`endif
         ST_RSP: begin
            rsp_valid = 1'b1;
            cnt_clr   = 1'b1;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (Reset) begin
         state  <= ST_INIT;
         cnt    <= '0;
         op_q   <= OP_RESET;
         len_q  <= '0;
         data_q <= '0;
         rsp_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_clr ? '0 : cnt + 1'b1;
         if (accept) begin
            op_q   <= op_t'(cmd_op);
            len_q  <= (op_t'(cmd_op) == OP_RUNTEST) ? cmd_len : len_clamp;
            data_q <= cmd_data;
            rsp_q  <= '0;
         end
         if (shift_en) rsp_q[cnt] <= tdo_bit;
      end
   end

   tap_state_mirror u_mirror (
      .TCK       (TCK),
      .Reset     (Reset),
      .TMS       (TMS),
      .tap_state (tap_q)
   );

endmodule

// File: tb/tb_jtag_scan_driver.sv
// Bench for jtag_scan_driver: directed table against a small behavioural TAP, then random commands.
`timescale 1ns/1ps
module tb_jtag_scan_driver;
   import jtag_scan_driver_pkg::*;

   localparam int N  = 16;
   localparam int CL = 3*N + 3;
   localparam int LW = $clog2(CL + 1);
   localparam logic [CL-1:0] CAP_VAL = 51'h5_A3C9_6E1F_0B27;

   logic          TCK = 1'b0;
   logic          Reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [LW-1:0] cmd_len = '0;
   logic [CL-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [CL-1:0] rsp_data;
   logic          TMS, TDI, TDO;
   logic [3:0]    tap_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 TCK = ~TCK;

   jtag_scan_driver #(.N(N)) dut (
      .TCK(TCK), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .TMS(TMS), .TDI(TDI), .TDO(TDO), .tap_state(tap_state)
   );

   // Behavioural TAP: 2-bit IR (00 = EXTEST on boundary chain, else BYPASS)
   bit            use_tap = 1'b0;
   logic          rnd_tdo = 1'b0;
   logic          tap_tdo;
   tap_state_t    tst = TAP_TLR;
   logic [1:0]    tap_ir = 2'b11;
   logic [1:0]    tap_irsr = 2'b00;
   logic [CL-1:0] tap_drsr = '0;

   function automatic tap_state_t tb_next(input tap_state_t s, input logic m);
      case (s)
         TAP_TLR:      return m ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      return m ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   return m ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_SEL_IR:   return m ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_DR, TAP_SHIFT_DR: return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_CAP_IR, TAP_SHIFT_IR: return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_DR: return m ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_EXIT1_IR: return m ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_DR: return m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_PAUSE_IR: return m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_DR: return m ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_EXIT2_IR: return m ? TAP_UPD_IR   : TAP_SHIFT_IR;
         default:      return m ? TAP_SEL_DR   : TAP_RTI;
      endcase
   endfunction

   always @(posedge TCK) begin
      case (tst)
         TAP_TLR:      tap_ir   <= BYPASS_IR;
         TAP_CAP_IR:   tap_irsr <= 2'b01;
         TAP_SHIFT_IR: tap_irsr <= {TDI, tap_irsr[1]};
         TAP_UPD_IR:   tap_ir   <= tap_irsr;
         TAP_CAP_DR:   tap_drsr <= (tap_ir == 2'b00) ? CAP_VAL : '0;
         TAP_SHIFT_DR: tap_drsr <= (tap_ir == 2'b00) ? {TDI, tap_drsr[CL-1:1]} : CL'(TDI);
         default: ;
      endcase
      tst <= tb_next(tst, TMS);
   end

   always_comb begin
      tap_tdo = 1'b0;
      if (tst == TAP_SHIFT_IR) tap_tdo = tap_irsr[0];
      if (tst == TAP_SHIFT_DR) tap_tdo = tap_drsr[0];
   end
   assign TDO = use_tap ? tap_tdo : rnd_tdo;

   task automatic chk(input string name, input logic [CL-1:0] got, input logic [CL-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Expected per-cycle TMS/TDI stream after accept, derived from the command rules
   bit exp_tms[$];
   bit exp_tdi[$];
   int sh_start, sh_len;

   function automatic void push(input bit m, input bit d);
      exp_tms.push_back(m);
      exp_tdi.push_back(d);
   endfunction

   function automatic void build_seq(input logic [1:0] op, input int len, input logic [CL-1:0] data);
      int l;
      l = (len > CL) ? CL : len;
      exp_tms.delete();
      exp_tdi.delete();
      sh_start = 0;
      sh_len   = 0;
      if (op == 2'b00) begin
         for (int i = 0; i < 5; i++) push(1'b1, 1'b0);
         push(1'b0, 1'b0);
      end else if (op == 2'b11) begin
`ifdef JTAG_SCAN_DRIVER_RUNTEST_EN
         for (int i = 0; i < len; i++) push(1'b0, 1'b0);
`endif
      end else if (l > 0) begin
         push(1'b1, 1'b0);
         if (op == 2'b01) push(1'b1, 1'b0);
         push(1'b0, 1'b0);
         push(1'b0, 1'b0);
         sh_start = exp_tms.size();
         sh_len   = l;
         for (int k = 0; k < l; k++) push(k == l - 1, data[k]);
         push(1'b1, 1'b0);
         push(1'b0, 1'b0);
      end
   endfunction

   task automatic issue(input logic [1:0] op, input int len, input logic [CL-1:0] data);
      int w;
      w = 0;
      while (!cmd_ready && w < 20) begin
         @(negedge TCK);
         w++;
      end
      chk("cmd_ready_wait", CL'(cmd_ready), CL'(1));
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = LW'(len);
      cmd_data  = data;
      @(negedge TCK);
      cmd_valid = 1'b0;
      cmd_data  = ~data;
   endtask

   task automatic run_cmd(input logic [1:0] op, input int len, input logic [CL-1:0] data,
                          input int hold, input logic [CL-1:0] want);
      logic [CL-1:0] exp_rsp, held;
      int w;
      build_seq(op, len, data);
      exp_rsp = use_tap ? want : '0;
      issue(op, len, data);
      for (int c = 0; c < exp_tms.size(); c++) begin
         chk($sformatf("rsp_early c%0d", c), CL'(rsp_valid), CL'(0));
         chk($sformatf("tms c%0d", c), CL'(TMS), CL'(exp_tms[c]));
         chk($sformatf("tdi c%0d", c), CL'(TDI), CL'(exp_tdi[c]));
         chk($sformatf("tap c%0d", c), CL'(tap_state), CL'(tst));
         if (c == 0) chk("cmd_ready_busy", CL'(cmd_ready), CL'(0));
         if (!use_tap) begin
            rnd_tdo = 1'($urandom);
            if (c >= sh_start && c < sh_start + sh_len) exp_rsp[c - sh_start] = rnd_tdo;
         end
         @(negedge TCK);
      end
      chk("rsp_latency", CL'(rsp_valid), CL'(1));
      w = 0;
      while (!rsp_valid && w < 100) begin
         @(negedge TCK);
         w++;
      end
      chk("rsp_data", rsp_data, exp_rsp);
      chk("tap_end_rti", CL'(tap_state), CL'(TAP_RTI));
      chk("cmd_ready_rsp", CL'(cmd_ready), CL'(0));
      held = rsp_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge TCK);
         chk("hold_valid", CL'(rsp_valid), CL'(1));
         chk("hold_data", rsp_data, held);
         chk("hold_ready", CL'(cmd_ready), CL'(0));
      end
      rsp_ready = 1'b1;
      @(negedge TCK);
      rsp_ready = 1'b0;
      chk("rsp_drop", CL'(rsp_valid), CL'(0));
      chk("ready_after_rsp", CL'(cmd_ready), CL'(1));
   endtask

   task automatic do_reset(input int cyc);
      Reset     = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (cyc) @(negedge TCK);
      chk("rst_tms", CL'(TMS), CL'(1));
      chk("rst_tdi", CL'(TDI), CL'(0));
      chk("rst_cmd_ready", CL'(cmd_ready), CL'(0));
      chk("rst_rsp_valid", CL'(rsp_valid), CL'(0));
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_tap", CL'(tap_state), CL'(TAP_TLR));
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("init_tms %0d", i), CL'(TMS), CL'(i < 5));
         chk($sformatf("init_ready %0d", i), CL'(cmd_ready), CL'(0));
         @(negedge TCK);
      end
      chk("init_ready_rise", CL'(cmd_ready), CL'(1));
      chk("init_tap_rti", CL'(tap_state), CL'(TAP_RTI));
      chk("init_tap_model", CL'(tst), CL'(TAP_RTI));
   endtask

   typedef struct {
      logic [1:0]    op;
      int            len;
      logic [CL-1:0] data;
      int            hold;
      logic [CL-1:0] exp;
   } vec_t;

   initial begin
      vec_t          tbl[10];
      logic [CL-1:0] ones_shifted;
      ones_shifted = {{(CL-1){1'b1}}, 1'b0};
      tbl[0] = '{2'b01, 2,  CL'(2'b11),   0,  CL'(2'b01)};
      tbl[1] = '{2'b10, 4,  CL'(4'b1011), 0,  CL'(4'b0110)};
      tbl[2] = '{2'b01, 2,  CL'(2'b00),   10, CL'(2'b01)};
      tbl[3] = '{2'b10, 51, CL'(1) << 20, 0,  CAP_VAL};
      tbl[4] = '{2'b10, 51, CL'(1),       2,  CAP_VAL};
      tbl[5] = '{2'b10, 0,  '1,           0,  '0};
      tbl[6] = '{2'b11, 5,  '1,           0,  '0};
      tbl[7] = '{2'b00, 0,  '0,           1,  '0};
      tbl[8] = '{2'b10, 60, '1,           0,  ones_shifted};
      tbl[9] = '{2'b01, 1,  CL'(1),       0,  CL'(1)};

      do_reset(3);

      use_tap = 1'b1;
      for (int i = 0; i < 10; i++)
         run_cmd(tbl[i].op, tbl[i].len, tbl[i].data, tbl[i].hold, tbl[i].exp);

      // Reset landing on shift bit 20 of a full-chain DR scan
      issue(2'b10, 51, {$urandom, $urandom});
      for (int c = 0; c < 23; c++) begin
         chk("abort_no_rsp", CL'(rsp_valid), CL'(0));
         @(negedge TCK);
      end
      chk("abort_in_shift", CL'(tap_state), CL'(TAP_SHIFT_DR));
      do_reset(3);
      run_cmd(2'b10, 0, '1, 0, '0);

      use_tap = 1'b0;
      for (int i = 0; i < 40; i++)
         run_cmd(2'($urandom), int'($urandom_range(0, 63)), {$urandom, $urandom},
                 int'($urandom_range(0, 2)), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule
